// File: rtl/frame_config_receiver.sv
// Byte-stream receiver for checksummed WRITE/COMMIT/CLEAR configuration frames.
// Frame writes land in a shadow bank, and COMMIT copies the shadow bank into the active bank that drives cfg_words.
module frame_config_receiver #(
    parameter int WIDTH       = 8,
    parameter int WORD        = 32,
    parameter int N_CHANNELS  = 16,
    parameter int CH_REGS     = 4,
    parameter int GLOBAL_REGS = 2,
    parameter int MAX_BURST   = 8
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic [WIDTH-1:0]                                sig_in,
    input  logic                                            in_valid,
    input  logic                                            frame_abort,
    output logic                                            busy,
    output logic [(GLOBAL_REGS+N_CHANNELS*CH_REGS)*WORD-1:0] cfg_words,
    output logic [WORD-1:0]                                 volume,
    output logic [WORD-1:0]                                 reverb,
    output logic                                            cfg_update,
    output logic                                            err,
    output logic [1:0]                                      err_code
);
    localparam int N_REGS = GLOBAL_REGS + N_CHANNELS * CH_REGS;
    localparam int BPW    = WORD / WIDTH;
    localparam int BCW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [WIDTH-1:0] CMD_WRITE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CMD_COMMIT = WIDTH'(2);
    localparam logic [WIDTH-1:0] CMD_CLEAR  = WIDTH'(3);

    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_UNKNOWN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHECK, ST_DISCARD
    } state_t;

    typedef enum logic [1:0] {OP_WRITE, OP_COMMIT, OP_CLEAR} op_t;

    state_t           state, state_nxt;
    op_t              op;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] chk_acc;
    logic [SW-1:0]    word_cnt;
    logic [SW-1:0]    last_word;
    logic [BCW-1:0]   byte_cnt;
    logic [WORD-1:0]  staging [MAX_BURST];
    logic [WORD-1:0]  shadow  [N_REGS];
    logic [WORD-1:0]  active  [N_REGS];

    logic       err_set;
    logic [1:0] err_val;
    logic       do_write, do_commit, do_clear;
    logic       len_bad, last_byte, payload_done;

    assign len_bad = (sig_in == '0)
                  || (32'(sig_in) > 32'(MAX_BURST))
                  || (32'(addr) + 32'(sig_in) > 32'(N_REGS));
    assign last_byte    = (byte_cnt == BCW'(BPW - 1));
    assign payload_done = last_byte && (word_cnt == last_word);
    assign busy         = (state != ST_IDLE);

    // NOTE: state-holding regs use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = ERR_RANGE;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_clear  = 1'b0;
        if (frame_abort) begin
            // Abort wins over a coincident byte; it is an error only inside a live frame.
            state_nxt = ST_IDLE;
            if (state != ST_IDLE && state != ST_DISCARD) err_set = 1'b1;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (sig_in == CMD_WRITE) begin
                        state_nxt = ST_ADDR;
                    end else if (sig_in == CMD_COMMIT || sig_in == CMD_CLEAR) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_DISCARD;
                        err_set   = 1'b1;
                        err_val   = ERR_UNKNOWN;
                    end
                end
                ST_ADDR: state_nxt = ST_LEN;
                ST_LEN: begin
                    if (len_bad) begin
                        state_nxt = ST_DISCARD;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (payload_done) state_nxt = ST_CHECK;
                ST_CHECK: begin
                    state_nxt = ST_IDLE;
                    if (sig_in == chk_acc) begin
                        do_write  = (op == OP_WRITE);
                        do_commit = (op == OP_COMMIT);
                        do_clear  = (op == OP_CLEAR);
                    end else begin
                        err_set = 1'b1;
                        err_val = ERR_CHECKSUM;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Frame parsing datapath: running checksum, header capture, payload assembly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op         <= OP_WRITE;
            addr       <= '0;
            chk_acc    <= '0;
            word_cnt   <= '0;
            last_word  <= '0;
            byte_cnt   <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            cfg_update <= 1'b0;
            for (int i = 0; i < MAX_BURST; i++) staging[i] <= '0;
        end else begin
            err        <= err_set;
            cfg_update <= do_commit;
            if (err_set) err_code <= err_val;
            if (frame_abort) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                for (int i = 0; i < MAX_BURST; i++) staging[i] <= '0;
            end else if (in_valid) begin
                chk_acc <= chk_acc ^ sig_in;
                case (state)
                    ST_IDLE: begin
                        chk_acc  <= sig_in;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        op       <= (sig_in == CMD_COMMIT) ? OP_COMMIT :
                                    (sig_in == CMD_CLEAR)  ? OP_CLEAR  : OP_WRITE;
                    end
                    ST_ADDR: addr      <= sig_in;
                    ST_LEN:  last_word <= SW'(sig_in - WIDTH'(1));
                    ST_PAYLOAD: begin
                        // Little-endian: shifting right leaves the first byte in the low lane.
                        staging[word_cnt] <= (staging[word_cnt] >> WIDTH)
                                           | (WORD'(sig_in) << (WORD - WIDTH));
                        if (last_byte) begin
                            byte_cnt <= '0;
                            word_cnt <= word_cnt + SW'(1);
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: both banks are reset to zero because cfg_words must read zero straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (do_clear)
                    shadow[i] <= '0;
                else if (do_write && i >= int'(addr) && i <= int'(addr) + int'(last_word))
                    shadow[i] <= staging[SW'(i - int'(addr))];
                if (do_commit) active[i] <= shadow[i];
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_cfg
        assign cfg_words[g*WORD +: WORD] = active[g];
    end

    assign volume = active[0];
    assign reverb = active[1];

endmodule

// File: tb/tb_frame_config_receiver.sv
// Self-checking bench for frame_config_receiver: directed frames plus random frames.
// Each frame is scored against a frame-level reference model of the shadow and active banks.
module tb_frame_config_receiver;
    localparam int WIDTH       = 8;
    localparam int WORD        = 32;
    localparam int N_CHANNELS  = 16;
    localparam int CH_REGS     = 4;
    localparam int GLOBAL_REGS = 2;
    localparam int MAX_BURST   = 8;
    localparam int N_REGS      = GLOBAL_REGS + N_CHANNELS * CH_REGS;
    localparam int BPW         = WORD / WIDTH;

    typedef logic [7:0] byte_t;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [WIDTH-1:0]         sig_in;
    logic                     in_valid;
    logic                     frame_abort;
    logic                     busy;
    logic [N_REGS*WORD-1:0]   cfg_words;
    logic [WORD-1:0]          volume;
    logic [WORD-1:0]          reverb;
    logic                     cfg_update;
    logic                     err;
    logic [1:0]               err_code;

    frame_config_receiver #(
        .WIDTH(WIDTH), .WORD(WORD), .N_CHANNELS(N_CHANNELS),
        .CH_REGS(CH_REGS), .GLOBAL_REGS(GLOBAL_REGS), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rstn(rstn), .sig_in(sig_in), .in_valid(in_valid),
        .frame_abort(frame_abort), .busy(busy), .cfg_words(cfg_words),
        .volume(volume), .reverb(reverb), .cfg_update(cfg_update),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int upd_seen = 0;

    logic [WORD-1:0] m_shadow [N_REGS];
    logic [WORD-1:0] m_active [N_REGS];
    int              m_code;

    always @(negedge clk) begin
        if (rstn) begin
            if (err)        err_seen++;
            if (cfg_update) upd_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_cfg();
        for (int i = 0; i < N_REGS; i++)
            check($sformatf("cfg_words[%0d]", i),
                  64'(cfg_words[i*WORD +: WORD]), 64'(m_active[i]));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_REGS; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_code = 0;
    endfunction

    function automatic byte_t xor_of(input byte_t q[$]);
        byte_t x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    // Frame-level reference: abort_at is the index of the byte dropped by abort (-1: none).
    function automatic void model_frame(input byte_t q[$], input int abort_at,
                                        output int e, output int u, output bit disc);
        int n, total, addr, len;
        e = 0; u = 0; disc = 1'b0;
        n = (abort_at < 0) ? q.size() : abort_at;
        if (n == 0) return;
        if (q[0] < 8'd1 || q[0] > 8'd3) begin
            e = 1; m_code = 3; disc = 1'b1;
            return;
        end
        addr = 0; len = 0;
        if (q[0] == 8'd1) begin
            if (n < 3) begin e = 1; m_code = 2; return; end
            addr = int'(q[1]);
            len  = int'(q[2]);
            if (len == 0 || len > MAX_BURST || addr + len > N_REGS) begin
                e = 1; m_code = 2; disc = 1'b1;
                return;
            end
            total = 4 + len * BPW;
        end else begin
            total = 2;
        end
        if (n < total) begin e = 1; m_code = 2; return; end
        if (q[total-1] != xor_of(q[0:total-2])) begin e = 1; m_code = 1; return; end
        case (q[0])
            8'd1: for (int w = 0; w < len; w++)
                      m_shadow[addr+w] = {q[3+w*4+3], q[3+w*4+2], q[3+w*4+1], q[3+w*4]};
            8'd2: begin
                      for (int i = 0; i < N_REGS; i++) m_active[i] = m_shadow[i];
                      u = 1;
                  end
            default: for (int i = 0; i < N_REGS; i++) m_shadow[i] = '0;
        endcase
    endfunction

    // Drives one frame back to back, then a standalone abort cycle, then scores it.
    task automatic run_frame(input byte_t q[$], input int abort_at);
        int e0, u0, exp_err, exp_upd;
        bit disc;
        logic busy_now, upd_now;
        logic [WORD-1:0] vol_now;
        e0 = err_seen;
        u0 = upd_seen;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            sig_in      = q[i];
            in_valid    = 1'b1;
            frame_abort = (i == abort_at);
            if (i == abort_at) break;
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        frame_abort = 1'b0;
        @(negedge clk);
        busy_now = busy;
        upd_now  = cfg_update;
        vol_now  = volume;
        @(posedge clk); #1 frame_abort = 1'b1;
        @(posedge clk); #1 frame_abort = 1'b0;
        repeat (2) @(negedge clk);
        model_frame(q, abort_at, exp_err, exp_upd, disc);
        check("err_pulses", 64'(err_seen - e0), 64'(exp_err));
        check("upd_pulses", 64'(upd_seen - u0), 64'(exp_upd));
        check("err_code", 64'(err_code), 64'(m_code));
        check("busy_in_frame", 64'(busy_now), 64'(disc));
        check("busy_after_abort", 64'(busy), 64'(0));
        check("upd_first_cycle", 64'(upd_now), 64'(exp_upd));
        if (exp_upd != 0) check("volume_first_cycle", 64'(vol_now), 64'(m_active[0]));
        check_cfg();
    endtask

    function automatic void mk_write(input int addr, input int len, input bit bad,
                                     output byte_t q[$]);
        byte_t c;
        q = {8'h01, byte_t'(addr), byte_t'(len)};
        for (int i = 0; i < len * BPW; i++) q.push_back(byte_t'($urandom));
        c = xor_of(q);
        q.push_back(bad ? (c ^ 8'h01) : c);
    endfunction

    task automatic random_frame();
        byte_t q[$];
        int kind, len, addr, ab, sel;
        byte_t x;
        kind = $urandom_range(0, 9);
        ab   = -1;
        len  = $urandom_range(1, MAX_BURST);
        addr = $urandom_range(0, N_REGS - len);
        case (kind)
            0, 1, 2: mk_write(addr, len, 1'b0, q);
            3:       mk_write(addr, len, 1'b1, q);
            4, 5:    q = {8'h02, 8'h02};
            6:       q = {8'h03, 8'h03};
            7: begin
                do x = byte_t'($urandom); while (x >= 8'd1 && x <= 8'd3);
                q = {x, byte_t'($urandom), byte_t'($urandom)};
            end
            8: begin
                sel = $urandom_range(0, 2);
                if (sel == 0) begin
                    len = 0;
                end else if (sel == 1) begin
                    len = $urandom_range(MAX_BURST + 1, 255);
                end else begin
                    addr = $urandom_range(N_REGS - len + 1, 255);
                end
                q = {8'h01, byte_t'(addr), byte_t'(len),
                     byte_t'($urandom), byte_t'($urandom), byte_t'($urandom)};
            end
            default: begin
                mk_write(addr, len, 1'b0, q);
                ab = $urandom_range(0, q.size() - 1);
            end
        endcase
        run_frame(q, ab);
    endtask

    initial begin
        byte_t q[$];
        rstn        = 1'b0;
        sig_in      = '0;
        in_valid    = 1'b0;
        frame_abort = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_err_code", 64'(err_code), 64'(0));
        check("reset_cfg_update", 64'(cfg_update), 64'(0));
        check_cfg();

        // Bad checksum, then commit of a still-zero shadow bank.
        run_frame({8'h01, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09}, -1);
        run_frame({8'h02, 8'h02}, -1);
        check("volume_bad_chk", 64'(volume), 64'(0));

        // Good write and commit.
        run_frame({8'h01, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, -1);
        run_frame({8'h02, 8'h02}, -1);
        check("volume_write_commit", 64'(volume), 64'(32'h1234_5678));

        // Range error at LEN, trailing bytes ignored until abort.
        run_frame({8'h01, 8'h41, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, -1);
        // Unknown command.
        run_frame({8'h7F, 8'h01, 8'h02}, -1);
        // Abort coincident with a payload byte, then commit shows shadow untouched.
        mk_write(0, 2, 1'b0, q);
        run_frame(q, 5);
        run_frame({8'h02, 8'h02}, -1);
        check("volume_after_abort", 64'(volume), 64'(32'h1234_5678));

        // Maximum burst to ADDR=2, commit, then clear and commit.
        mk_write(2, MAX_BURST, 1'b0, q);
        run_frame(q, -1);
        run_frame({8'h02, 8'h02}, -1);
        run_frame({8'h03, 8'h03}, -1);
        run_frame({8'h02, 8'h02}, -1);

        for (int f = 0; f < 150; f++) random_frame();

        // Asynchronous reset in the middle of a payload.
        mk_write(0, 1, 1'b0, q);
        run_frame(q, -1);
        run_frame({8'h02, 8'h02}, -1);
        run_frame({8'h55}, -1);
        q = {8'h01, 8'h00, 8'h02, 8'hAA, 8'hBB};
        foreach (q[i]) begin
            @(posedge clk); #1;
            sig_in   = q[i];
            in_valid = 1'b1;
        end
        @(posedge clk); #2;
        check("busy_mid_payload", 64'(busy), 64'(1));
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_err_code", 64'(err_code), 64'(0));
        check("rst_cfg_update", 64'(cfg_update), 64'(0));
        check("rst_cfg_any", 64'(|cfg_words), 64'(0));
        in_valid = 1'b0;
        @(posedge clk); #3 rstn = 1'b1;
        run_frame({8'h01, 8'h01, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01 ^ 8'h01 ^ 8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE}, -1);
        run_frame({8'h02, 8'h02}, -1);
        check("reverb_after_reset", 64'(reverb), 64'(32'hDEAD_BEEF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_config_receiver.md
FRAME_CONFIG_RECEIVER -- requirements
Module: frame_config_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: byte width of the receive stream.
REQ-002 SHALL have parameter WORD, default 32: configuration word width; WORD is a multiple of WIDTH; BPW = WORD/WIDTH.
REQ-003 SHALL have parameter N_CHANNELS, default 16: oscillator channel count.
REQ-004 SHALL have parameter CH_REGS, default 4: words per channel.
REQ-005 SHALL have parameter GLOBAL_REGS, default 2: global words.
  - N_REGS = GLOBAL_REGS + N_CHANNELS*CH_REGS, which SHALL be at most 256.
REQ-006 SHALL have parameter MAX_BURST, default 8: maximum words per write frame.
REQ-007 SHALL have the following ports:
  - clk  in  1  system clock; all state on rising edge.
  - rstn  in  1  reset; one clock; reset is asynchronous and active-low.
  - sig_in  in  WIDTH  received byte.
  - in_valid  in  1  single-cycle strobe; sig_in valid; no backpressure.
  - frame_abort  in  1  chip-select release; terminates current frame.
  - busy  out  1  high whenever state is not IDLE.
  - cfg_words  out  N_REGS x WORD  active configuration.
  - volume  out  WORD  equals cfg_words[0].
  - reverb  out  WORD  equals cfg_words[1].
  - cfg_update  out  1  one-cycle pulse when active configuration changes.
  - err  out  1  one-cycle pulse on frame error.
  - err_code  out  2  last error: 0 none, 1 checksum, 2 range/length, 3 unknown command.

Function
REQ-008 SHALL hold two register banks: shadow[N_REGS] and active[N_REGS]; cfg_words SHALL be driven from active only.
REQ-009 Frame format SHALL be as follows.
  - CMD, then command-specific bytes, then CHK.
  - CHK SHALL equal the XOR of all preceding bytes of the frame.
REQ-010 Commands SHALL be:
  - 0x01 WRITE: CMD, ADDR, LEN, LEN*BPW payload bytes (little-endian; first byte = bits WIDTH-1:0), CHK.
  - 0x02 COMMIT: CMD, CHK.
  - 0x03 CLEAR: CMD, CHK.
REQ-011 FSM states SHALL be IDLE, ADDR, LEN, PAYLOAD, CHECK, DISCARD; each transition SHALL be taken only on a cycle with in_valid=1, except abort/reset.
REQ-012 In IDLE, the block SHALL decode CMD as follows.
  - 0x01 -> ADDR.
  - 0x02/0x03 -> CHECK.
  - Other -> DISCARD, with err pulse and err_code=3.
REQ-013 At the LEN byte, LEN=0, LEN>MAX_BURST or ADDR+LEN>N_REGS SHALL cause err pulse, err_code=2 and a transition to DISCARD.
REQ-014 Payload bytes SHALL be assembled into a MAX_BURST-word staging buffer; shadow SHALL NOT be modified before the checksum passes.
REQ-015 On the CHK byte, the block SHALL return to IDLE and act as follows.
  - Match, WRITE: shadow[ADDR..ADDR+LEN-1] <= staging, visible the next cycle.
  - Match, COMMIT: active <= shadow, all words in one cycle; cfg_update pulses the same cycle active changes.
  - Match, CLEAR: shadow <= 0; active is unchanged.
  - Mismatch: no register change; err pulse; err_code=1.
REQ-016 DISCARD SHALL ignore bytes until frame_abort, then go to IDLE.
REQ-017 frame_abort=1 SHALL force IDLE on the next edge from any state and drop staging.
  - frame_abort has priority over a simultaneous in_valid byte, which SHALL be dropped.
  - Abort in IDLE or DISCARD is silent.
  - Abort in ADDR, LEN, PAYLOAD or CHECK SHALL pulse err with err_code=2.
REQ-018 A new frame SHALL be accepted the cycle after the CHK byte; back-to-back in_valid every cycle SHALL be supported.
REQ-019 err_code SHALL hold until the next error or reset; err and cfg_update SHALL never be high for more than one cycle per event.

Reset
REQ-020 rstn low SHALL asynchronously clear the following.
  - shadow, active and staging.
  - Counters.
  - err, err_code and cfg_update.
  - The FSM, to IDLE; busy=0.
REQ-021 Reset asserted mid-frame SHALL discard the frame; the first byte after rstn rises SHALL be decoded as CMD.

Verification
REQ-022 Write and commit: 01 00 01 78 56 34 12 08, then 02 02 -> volume=0x12345678 one cycle after the final CHK, with cfg_update pulsed once and err never asserted.
REQ-023 Bad checksum: 01 00 01 78 56 34 12 09 then 02 02 -> err pulse, err_code=1, volume stays 0.
REQ-024 Range: 01 41 02 ... (defaults, N_REGS=66) -> err_code=2 at LEN byte, remaining bytes ignored until frame_abort, busy=1 then 0.
REQ-025 Unknown command 7F -> err_code=3; abort mid-PAYLOAD -> err_code=2, shadow unchanged; abort simultaneous with a byte -> byte dropped.
REQ-026 Burst of MAX_BURST words to ADDR=2 with back-to-back bytes, commit, then CLEAR+COMMIT -> first commit matches the payload, second commit zeroes all cfg_words.
REQ-027 rstn pulsed low mid-payload -> all outputs 0 immediately; subsequent valid frame processed correctly.
